// File: rtl/step_dir_generator.sv
// Step/direction pulse generator: accepts a motion command over valid/ready,
// emits a timed step pulse train after a direction setup delay, tracks signed position.
module step_dir_generator #(
    parameter int CNT_W      = 16,
    parameter int PER_W      = 24,
    parameter int POS_W      = 32,
    parameter int PULSE_HIGH = 4,
    parameter int DIR_SETUP  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

    localparam logic [PER_W-1:0] MIN_PERIOD = PER_W'(2 * PULSE_HIGH);
    localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'(DIR_SETUP - 1);
    localparam logic [PER_W-1:0] HIGH_LOAD  = PER_W'(PULSE_HIGH - 1);
    localparam logic [PER_W-1:0] LOW_BIAS   = PER_W'(PULSE_HIGH + 1);

    state_t             state;
    logic [PER_W-1:0]   cnt;
    logic [PER_W-1:0]   low_load;
    logic [CNT_W-1:0]   remaining;
    logic               abort_pend;
    logic [PER_W-1:0]   eff_period;
    logic [PER_W-1:0]   low_len;
    logic [POS_W-1:0]   step_delta;

    assign cmd_ready = (state == S_IDLE);

    // Clamp the requested period and derive the low-phase down-counter preload.
    always_comb begin
        eff_period = cmd_period;
        if (cmd_period < MIN_PERIOD) begin
            eff_period = MIN_PERIOD;
        end else begin
            eff_period = cmd_period;
        end
        low_len = eff_period - LOW_BIAS;
    end

    // Position increment follows the latched direction, not the live command input.
    always_comb begin
        step_delta = POS_W'(1);
        if (dir_out) begin
            step_delta = POS_W'(1);
        end else begin
            step_delta = {POS_W{1'b1}};
        end
    end

    // Command sequencer with registered pulse, direction, status and position outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            low_load   <= '0;
            remaining  <= '0;
            abort_pend <= 1'b0;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dir_out    <= cmd_dir;
                        low_load   <= low_len;
                        remaining  <= cmd_steps;
                        abort_pend <= 1'b0;
                        if (cmd_steps != CNT_W'(0)) begin
                            state <= S_SETUP;
                            busy  <= 1'b1;
                            cnt   <= SETUP_LOAD;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt == PER_W'(0)) begin
                        state     <= S_HIGH;
                        step_out  <= 1'b1;
                        position  <= position + step_delta;
                        remaining <= remaining - CNT_W'(1);
                        cnt       <= HIGH_LOAD;
                    end else begin
                        cnt <= cnt - PER_W'(1);
                    end
                end
                S_HIGH: begin
                    // An abort here is deferred so the pulse keeps its full width.
                    if (cnt == PER_W'(0)) begin
                        step_out <= 1'b0;
                        if (abort_pend || abort) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOW;
                            cnt   <= low_load;
                        end
                    end else begin
                        cnt <= cnt - PER_W'(1);
                        if (abort) begin
                            abort_pend <= 1'b1;
                        end else begin
                            abort_pend <= abort_pend;
                        end
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt == PER_W'(0)) begin
                        if (remaining != CNT_W'(0)) begin
                            state     <= S_HIGH;
                            step_out  <= 1'b1;
                            position  <= position + step_delta;
                            remaining <= remaining - CNT_W'(1);
                            cnt       <= HIGH_LOAD;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - PER_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    step_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_dir_generator.sv
// Directed self-checking bench for step_dir_generator (8-bit position build to reach wrap quickly).
module tb_step_dir_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [7:0]  position;

    int total = 0;
    int bad   = 0;

    int rise_t [0:31];
    int hi_w   [0:31];
    int nrise;
    int ndone;
    int done_t;
    bit dir_changed;

    always #5 clk = ~clk;

    step_dir_generator #(
        .CNT_W(16), .PER_W(24), .POS_W(8), .PULSE_HIGH(4), .DIR_SETUP(8)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .step_out(step_out), .dir_out(dir_out), .busy(busy),
        .done(done), .position(position)
    );

    // Present a command for one edge; returns at the falling edge of cycle accept+1.
    task automatic send_cmd(input logic d, input logic [15:0] s, input logic [23:0] p);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = s;
        cmd_period = p;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Observe ncyc cycles (t=1 is the first cycle after accept); optionally pulse abort in cycle abort_t.
    task automatic measure(input int ncyc, input int abort_t);
        logic prev;
        logic first_dir;
        int   hw;
        nrise = 0; ndone = 0; done_t = -1; prev = 1'b0; hw = 0;
        dir_changed = 1'b0; first_dir = dir_out;
        for (int t = 1; t <= ncyc; t++) begin
            if (step_out && !prev) begin
                if (nrise < 32) rise_t[nrise] = t;
                nrise++;
                hw = 0;
            end
            if (step_out) begin
                hw++;
                if (nrise >= 1 && nrise <= 32) hi_w[nrise-1] = hw;
            end
            if (done) begin
                ndone++;
                if (done_t < 0) done_t = t;
            end
            if (dir_out !== first_dir) dir_changed = 1'b1;
            prev  = step_out;
            abort = (t == abort_t);
            @(negedge clk);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++; if ({step_out, dir_out, busy, done} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {step_out, dir_out, busy, done}); end
        total++; if (position !== 8'h00) begin bad++; $display("FAIL reset_pos got=%h exp=00", position); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_basic();
        send_cmd(1'b1, 16'd3, 24'd20);
        total++; if ({busy, cmd_ready, dir_out} !== 3'b101) begin bad++; $display("FAIL basic_accept got=%b exp=101", {busy, cmd_ready, dir_out}); end
        measure(75, -1);
        total++; if (nrise !== 3) begin bad++; $display("FAIL basic_nrise got=%0d exp=3", nrise); end
        total++; if (rise_t[0] !== 9 || rise_t[1] !== 29 || rise_t[2] !== 49) begin bad++; $display("FAIL basic_rises got=%0d,%0d,%0d exp=9,29,49", rise_t[0], rise_t[1], rise_t[2]); end
        for (int i = 0; i < 3; i++) begin
            total++; if (hi_w[i] !== 4) begin bad++; $display("FAIL basic_width%0d got=%0d exp=4", i, hi_w[i]); end
        end
        total++; if (done_t !== 69 || ndone !== 1) begin bad++; $display("FAIL basic_done got t=%0d n=%0d exp t=69 n=1", done_t, ndone); end
        total++; if (position !== 8'd3) begin bad++; $display("FAIL basic_pos got=%0d exp=3", position); end
        total++; if ({busy, cmd_ready} !== 2'b01) begin bad++; $display("FAIL basic_idle got=%b exp=01", {busy, cmd_ready}); end
    endtask

    task automatic test_reverse();
        send_cmd(1'b0, 16'd5, 24'd10);
        total++; if (dir_out !== 1'b0) begin bad++; $display("FAIL rev_dir got=%b exp=0", dir_out); end
        measure(65, -1);
        total++; if (nrise !== 5 || rise_t[0] !== 9 || rise_t[4] !== 49) begin bad++; $display("FAIL rev_rises got n=%0d first=%0d last=%0d exp 5,9,49", nrise, rise_t[0], rise_t[4]); end
        total++; if (dir_changed !== 1'b0) begin bad++; $display("FAIL rev_dir_hold got=%b exp=0", dir_changed); end
        total++; if (done_t !== 59) begin bad++; $display("FAIL rev_done got=%0d exp=59", done_t); end
        total++; if (position !== 8'hFE) begin bad++; $display("FAIL rev_pos got=%h exp=fe", position); end
    endtask

    task automatic test_clamp();
        send_cmd(1'b1, 16'd2, 24'd3);
        measure(30, -1);
        total++; if (nrise !== 2 || rise_t[0] !== 9 || rise_t[1] !== 17) begin bad++; $display("FAIL clamp_rises got n=%0d %0d,%0d exp 2 9,17", nrise, rise_t[0], rise_t[1]); end
        total++; if (hi_w[0] !== 4 || hi_w[1] !== 4) begin bad++; $display("FAIL clamp_width got=%0d,%0d exp=4,4", hi_w[0], hi_w[1]); end
        total++; if (done_t !== 25) begin bad++; $display("FAIL clamp_done got=%0d exp=25", done_t); end
        total++; if (position !== 8'h00) begin bad++; $display("FAIL clamp_pos got=%h exp=00", position); end
    endtask

    task automatic test_zero();
        send_cmd(1'b1, 16'd0, 24'd50);
        total++; if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL zero_ready got=%b exp=10", {cmd_ready, busy}); end
        measure(10, -1);
        total++; if (done_t !== 1 || ndone !== 1) begin bad++; $display("FAIL zero_done got t=%0d n=%0d exp t=1 n=1", done_t, ndone); end
        total++; if (nrise !== 0 || position !== 8'h00) begin bad++; $display("FAIL zero_steps got n=%0d pos=%h exp 0 00", nrise, position); end
    endtask

    task automatic test_abort_high();
        send_cmd(1'b1, 16'd10, 24'd10);
        measure(40, 20);
        total++; if (nrise !== 2) begin bad++; $display("FAIL aborth_nrise got=%0d exp=2", nrise); end
        total++; if (hi_w[1] !== 4) begin bad++; $display("FAIL aborth_width got=%0d exp=4", hi_w[1]); end
        total++; if (done_t !== 23 || ndone !== 1) begin bad++; $display("FAIL aborth_done got t=%0d n=%0d exp t=23 n=1", done_t, ndone); end
        total++; if (position !== 8'd2) begin bad++; $display("FAIL aborth_pos got=%0d exp=2", position); end
    endtask

    task automatic test_abort_setup();
        send_cmd(1'b0, 16'd4, 24'd10);
        measure(20, 3);
        total++; if (nrise !== 0 || done_t !== 4) begin bad++; $display("FAIL aborts got n=%0d done=%0d exp 0 4", nrise, done_t); end
        total++; if (position !== 8'd2) begin bad++; $display("FAIL aborts_pos got=%0d exp=2", position); end
    endtask

    task automatic test_back_to_back();
        bit held_ok;
        send_cmd(1'b1, 16'd1, 24'd8);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        held_ok   = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            if (cmd_ready !== 1'b0 || dir_out !== 1'b1 || step_out !== ((t >= 9) && (t <= 12))) held_ok = 1'b0;
            @(negedge clk);
        end
        total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL b2b_holdoff got=%b exp=1", held_ok); end
        total++; if ({done, cmd_ready} !== 2'b11) begin bad++; $display("FAIL b2b_done got=%b exp=11", {done, cmd_ready}); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if ({dir_out, busy, done, cmd_ready} !== 4'b0100) begin bad++; $display("FAIL b2b_accept got=%b exp=0100", {dir_out, busy, done, cmd_ready}); end
        measure(20, -1);
        total++; if (nrise !== 1 || rise_t[0] !== 9 || done_t !== 17) begin bad++; $display("FAIL b2b_second got n=%0d rise=%0d done=%0d exp 1 9 17", nrise, rise_t[0], done_t); end
        total++; if (position !== 8'd2) begin bad++; $display("FAIL b2b_pos got=%0d exp=2", position); end
    endtask

    task automatic test_wrap();
        bit quiet;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_cmd(1'b1, 16'd127, 24'd8);
        measure(1030, -1);
        total++; if (nrise !== 127 || position !== 8'h7F) begin bad++; $display("FAIL wrap_max got n=%0d pos=%h exp 127 7f", nrise, position); end
        send_cmd(1'b1, 16'd1, 24'd8);
        measure(20, -1);
        total++; if (position !== 8'h80) begin bad++; $display("FAIL wrap_neg got=%h exp=80", position); end
        send_cmd(1'b1, 16'd3, 24'd8);
        repeat (9) @(negedge clk);
        total++; if (step_out !== 1'b1 || position !== 8'h81) begin bad++; $display("FAIL wrap_midpulse got step=%b pos=%h exp 1 81", step_out, position); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if ({step_out, done, busy, cmd_ready} !== 4'b0001 || position !== 8'h00) begin bad++; $display("FAIL rst_mid got=%b pos=%h exp=0001 00", {step_out, done, busy, cmd_ready}, position); end
        quiet = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (done !== 1'b0 || step_out !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rst_quiet got=%b exp=1", quiet); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_steps = 16'd0; cmd_period = 24'd0; abort = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_reverse();
        test_clamp();
        test_zero();
        test_abort_high();
        test_abort_setup();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
